mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/arb_rr_pick.sv | 40 ++++
 rtl/mem_bus_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory bus arbiter.
// Round-robin arbitration is selected by defining MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int MAX_NUM_REQ    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  // Input must be one-hot (or zero); OR-reduction avoids a priority chain.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_NUM_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_NUM_REQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational one-hot requester picker.
// MEM_ARB_ROUND_ROBIN_EN defined: search upward from i_ptr+1 with wrap; else highest index wins.
module arb_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
`endif
  output logic [NUM_REQ-1:0]         o_grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam int PTR_W = $clog2(NUM_REQ);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end
`else
  always_comb begin
    o_grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (i_req[k]) o_grant = NUM_REQ'(1) << k;
    end
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding memory bus arbiter: IDLE grants, BUSY drives memory, RESP pulses completion.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration (fixed priority otherwise).
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          system_flush,
  input  logic                          system_stall,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_grant,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          mem_req_valid,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_we,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  input  logic                          mem_data_valid
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_t              r_state;
  logic [PTR_W-1:0]        r_owner;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_we;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_mem_req_valid;
  logic [NUM_REQ-1:0]      r_rsp_valid;

  logic [NUM_REQ-1:0]      w_pick;
  logic [NUM_REQ-1:0]      w_grant;
  logic [PTR_W-1:0]        w_grant_idx;
  logic                    w_can_grant;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0]        r_rr_ptr;

  arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick)
  );
`else
  arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req   (req_valid),
    .o_grant (w_pick)
  );
`endif

  // Grant is combinational so a requester learns of acceptance in the same cycle.
  assign w_can_grant = !reset && !system_flush && !system_stall && (r_state == ST_IDLE);
  assign w_grant     = w_can_grant ? w_pick : '0;
  assign w_grant_idx = PTR_W'(onehot_to_idx(MAX_NUM_REQ'(w_pick)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_owner         <= '0;
      r_addr          <= '0;
      r_we            <= 1'b0;
      r_wdata         <= '0;
      r_rdata         <= '0;
      r_mem_req_valid <= 1'b0;
      r_rsp_valid     <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_rr_ptr        <= PTR_W'(NUM_REQ - 1);
`endif
    end else if (system_flush) begin
      r_state         <= ST_IDLE;
      r_mem_req_valid <= 1'b0;
      r_rsp_valid     <= '0;
    end else if (!system_stall) begin
      case (r_state)
        ST_IDLE: begin
          r_rsp_valid <= '0;
          if (|w_grant) begin
            r_owner         <= w_grant_idx;
            r_addr          <= req_addr[int'(w_grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            r_we            <= req_we[w_grant_idx];
            r_wdata         <= req_wdata[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            r_mem_req_valid <= 1'b1;
            r_state         <= ST_BUSY;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_rr_ptr        <= w_grant_idx;
`endif
          end
        end
        ST_BUSY: begin
          if (mem_data_valid) begin
            r_mem_req_valid <= 1'b0;
            r_rsp_valid     <= NUM_REQ'(1) << r_owner;
            if (!r_we) r_rdata <= mem_rdata;
            r_state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_rsp_valid <= '0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_mem_req_valid <= 1'b0;
          r_rsp_valid     <= '0;
          r_state         <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_grant     = w_grant;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rdata;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_addr      = r_addr;
  assign mem_we        = r_we;
  assign mem_wdata     = r_wdata;

endmodule
